gpio_in_capture: RTL
====================

Name: gpio_in_capture

Overview:
- Wishbone-slave GPIO input peripheral that directly feeds the LM32 SoC's JDin-style pins into software.
- Synchronises and debounces each external input bit, and captures rising/falling edges into a sticky write-1-to-clear register.
- Raises a level interrupt to the LM32 when an enabled captured edge is pending.

Parameters:
WIDTH, 4, number of input pins (1..32)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced level changes (>=1; 1 ms at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
gpio_i  in  WIDTH  raw asynchronous pin inputs
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  write enable
wb_adr_i  in  32  byte address; only [3:2] decoded
wb_sel_i  in  4  byte selects
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_ack_o  out  1  transfer acknowledge
irq_o  out  1  interrupt, active-high level

Behaviour:
- Reset: rst low asynchronously clears everything: sync FFs, debounce counters, IN=0, EDGE=0, MASK=0, wb_ack_o=0, wb_dat_o=0, irq_o=0. CFG resets to rise-enable all bits, fall-enable none.
- Reset mid-operation: an in-flight Wishbone transfer is dropped with no ack, and pending edges are lost.
- Synchroniser: 2-FF chain per bit, giving sync2.
- Debounce, per bit, with an independent counter of width clog2(DEBOUNCE_CYCLES+1):
  - If sync2 == IN[b], the counter is cleared.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, IN[b] <= sync2 on that edge and the counter clears.
  - Any glitch back to the old level before then restarts the count.
- Latency: IN updates on the (DEBOUNCE_CYCLES+2)-th rising edge, counting the first edge that samples the new level.
- Edge capture: on the edge where IN[b] updates 0->1 with CFG[b] set, EDGE[b] <= 1. Likewise 1->0 with CFG[b+16] set.
- irq_o registered: irq_o <= |(EDGE & MASK), i.e. one cycle after EDGE sets.
- Register map (word offsets; unused bits read 0):
  - 0x0 IN: RO, bits[WIDTH-1:0]; writes ignored.
  - 0x4 EDGE: R/W1C; writing 1 clears the bit, writing 0 has no effect.
  - 0x8 MASK: RW [WIDTH-1:0].
  - 0xC CFG: RW, [WIDTH-1:0] rise enable, [16+WIDTH-1:16] fall enable.
- Byte lanes: writes honour wb_sel_i per byte lane.
- Simultaneous events: hardware edge set and software W1C on the same bit in the same cycle -> set wins (bit stays 1).
- Wishbone handshake:
  - When cyc&stb&!ack, the write is performed or read data registered, and wb_ack_o=1 on the next edge.
  - Ack is a single-cycle pulse and is 0 in the following cycle, so back-to-back strobes are acked every other cycle.
  - Read data is the register value at the strobe edge.
  - wb_dat_o is held until the next read.
  - Transfers without cyc are ignored.

Test Plan:
- DEBOUNCE_CYCLES=4, WIDTH=4: release reset, hold gpio_i=0 -> IN=0, EDGE=0, irq_o=0. Read 0xC -> 0x0000000F, with ack exactly 1 cycle after stb.
- Set gpio_i=4'b0001 and hold -> IN=0x1 on the 6th edge, EDGE=0x1 same edge, irq_o stays 0 (MASK=0). Write MASK=0x1 -> irq_o=1 one cycle after the write takes effect.
- Glitch: gpio_i[1] high for 3 cycles then low -> IN[1] never changes, EDGE[1]=0. High for 10 cycles -> IN[1]=1.
- W1C: EDGE=0x3, write 0x4 with 0x2 -> EDGE=0x1. Arrange a new bit0 edge on the same edge as a W1C of bit0 -> EDGE[0]=1.
- CFG=0x000F0000 (fall only): gpio_i 0x8 -> 0x0 after stable high -> EDGE=0x8 only on the falling transition. Write with wb_sel_i=4'b0001 to CFG -> upper bytes unchanged.
- Assert rst low mid-read (stb high) -> no ack, all registers at reset values; after release, IN follows pins after DEBOUNCE_CYCLES+2 edges.

Source files
------------

// File: rtl/gpio_in_capture.sv
// gpio_in_capture: Wishbone GPIO input block.
// Each pin is synchronised, debounced and edge-detected. Captured edges are
// held in a sticky write-1-to-clear register. A level interrupt is raised
// while any captured edge is pending and unmasked.
// Register map (word offsets): 0x0 IN, 0x4 EDGE, 0x8 MASK, 0xC CFG.
// CFG layout: [WIDTH-1:0] enables rising-edge capture and [16+WIDTH-1:16]
// enables falling-edge capture. Pins 16 and above have no CFG slot of their
// own; they always capture rising edges and never falling edges.
module gpio_in_capture #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             irq_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FALL_W = (WIDTH > 16) ? 16 : WIDTH;
    // The debounced level flips on the edge where the count would reach
    // DEBOUNCE_CYCLES, so compare against one less.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]  sync1_reg;
    logic [WIDTH-1:0]  sync2_reg;
    logic [WIDTH-1:0]  in_vec;
    logic [WIDTH-1:0]  edge_vec;
    logic [WIDTH-1:0]  mask_vec;
    logic [WIDTH-1:0]  rise_vec;
    logic [FALL_W-1:0] fall_vec;
    logic [31:0]       byte_en;
    logic [31:0]       rd_data;
    logic [1:0]        reg_sel;
    logic              wb_req;
    logic              wr_req;
    logic              wr_edge;
    logic              wr_mask;
    logic              wr_cfg;
    logic              unused_ok;

    // A new request is accepted only while no ack is outstanding, so strobes
    // held high are serviced every other cycle.
    assign reg_sel = wb_adr_i[3:2];
    assign wb_req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_req  = wb_req & wb_we_i;
    assign wr_edge = wr_req & (reg_sel == 2'd1);
    assign wr_mask = wr_req & (reg_sel == 2'd2);
    assign wr_cfg  = wr_req & (reg_sel == 2'd3);

    // Only address bits [3:2] are decoded. Data and lane bits beyond WIDTH
    // have no storage behind them.
    assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i, byte_en};

    // Expand the byte selects to one enable per data bit.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_byte_en
            assign byte_en[gi] = wb_sel_i[gi / 8];
        end
    endgenerate

    // Two-flop synchroniser on every raw pin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= gpio_i;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_reg;
            logic             in_reg;
            logic             edge_reg;
            logic             mask_reg;
            logic             rise_en;
            logic             fall_en;
            logic             change;
            logic             set_edge;
            logic             clr_edge;

            // The debounced level flips this cycle.
            assign change   = (sync2_reg[gi] != in_reg) && (cnt_reg == CNT_LAST);
            assign set_edge = change & ((sync2_reg[gi] & rise_en) |
                                        (~sync2_reg[gi] & fall_en));
            assign clr_edge = wr_edge & byte_en[gi] & wb_dat_i[gi];

            // Debounce: count consecutive mismatching cycles. Any return to the
            // current level restarts the count.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                    in_reg  <= 1'b0;
                end else if (sync2_reg[gi] == in_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    in_reg  <= sync2_reg[gi];
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            // Sticky edge flag. A hardware set takes priority over a
            // software clear in the same cycle.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    edge_reg <= 1'b0;
                end else if (set_edge) begin
                    edge_reg <= 1'b1;
                end else if (clr_edge) begin
                    edge_reg <= 1'b0;
                end
            end

            // Interrupt mask bit, written through its byte lane.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mask_reg <= 1'b0;
                end else if (wr_mask && byte_en[gi]) begin
                    mask_reg <= wb_dat_i[gi];
                end
            end

            if (gi < 16) begin : g_cfg
                // Per-pin rise/fall capture enables. At reset every pin
                // captures rising edges only.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        rise_en <= 1'b1;
                        fall_en <= 1'b0;
                    end else if (wr_cfg) begin
                        if (byte_en[gi]) begin
                            rise_en <= wb_dat_i[gi];
                        end
                        if (byte_en[gi + 16]) begin
                            fall_en <= wb_dat_i[gi + 16];
                        end
                    end
                end
                assign fall_vec[gi] = fall_en;
            end else begin : g_cfg_fixed
                assign rise_en = 1'b1;
                assign fall_en = 1'b0;
            end

            assign in_vec[gi]   = in_reg;
            assign edge_vec[gi] = edge_reg;
            assign mask_vec[gi] = mask_reg;
            assign rise_vec[gi] = rise_en;
        end
    endgenerate

    // Read mux. Unimplemented bits read as zero.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0: rd_data[WIDTH-1:0] = in_vec;
            2'd1: rd_data[WIDTH-1:0] = edge_vec;
            2'd2: rd_data[WIDTH-1:0] = mask_vec;
            default: begin
                rd_data[WIDTH-1:0]   = rise_vec;
                rd_data[16 +: FALL_W] = fall_vec;
            end
        endcase
    end

    // Single-cycle ack. Read data is captured at the strobe edge and is held
    // until the next read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= wb_req;
            if (wb_req && !wb_we_i) begin
                wb_dat_o <= rd_data;
            end
        end
    end

    // Registered level interrupt: any pending edge that is unmasked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |(edge_vec & mask_vec);
        end
    end

endmodule
